// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser, mid-bit
// sampling, a one-cycle valid strobe per byte and framing-error detection.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             s1;
    logic             s2;
    logic             rx_s;

    // Two-stage synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx_i;
            s2 <= s1;
        end
    end

    assign rx_s = s2;

    // Receive FSM: start-bit qualification at half a bit, then one sample per
    // bit period so every sample lands mid-bit. Strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            rx_data_o      <= 8'h00;
            rx_valid_o     <= 1'b0;
            rx_frame_err_o <= 1'b0;
            rx_busy_o      <= 1'b0;
        end else begin
            rx_valid_o     <= 1'b0;
            rx_frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        rx_busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Line went high again: a glitch, not a start bit.
                            state     <= IDLE;
                            rx_busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data_o  <= shift;
                            rx_valid_o <= 1'b1;
                            state      <= IDLE;
                            rx_busy_o  <= 1'b0;
                        end else begin
                            // Keep the last good byte; wait out a break so a
                            // held-low line is not decoded as 0x00 frames.
                            rx_frame_err_o <= 1'b1;
                            state          <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        rx_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vectors for uart_rx at 50 MHz / 115200 baud.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int HALF_BIT  = (CLK_FREQ / BAUD_RATE) / 2;
    localparam int BIT_NS    = 8680;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_busy_o;

    int total = 0;
    int bad   = 0;

    // Pulse bookkeeping from a negedge monitor.
    int         vcnt = 0;
    int         ecnt = 0;
    int         viol = 0;
    logic [7:0] data_log[$];
    logic       prev_pulse = 1'b0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (rx_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_frame_err_o(rx_frame_err_o),
        .rx_busy_o     (rx_busy_o)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            vcnt = vcnt + 1;
            data_log.push_back(rx_data_o);
        end
        if (rx_frame_err_o) ecnt = ecnt + 1;
        if (rx_valid_o && rx_frame_err_o) viol = viol + 1;
        if ((rx_valid_o || rx_frame_err_o) && prev_pulse) viol = viol + 1;
        prev_pulse = rx_valid_o || rx_frame_err_o;
    end

    typedef struct {
        logic [7:0] data;
        int         bit_ns;
        logic       stop;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; leaves rx_i at the stop level.
    task automatic send_frame(input logic [7:0] d, input int bit_ns, input logic stop);
        rx_i = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            #(bit_ns);
        end
        rx_i = stop;
        #(bit_ns);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        #(n * BIT_NS);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        int e0;
        logic [7:0] prior;

        vecs[0] = '{8'h55, BIT_NS, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hC3, 8854,   1'b1, 1, 0, 8'hC3};
        vecs[2] = '{8'hC3, 8506,   1'b1, 1, 0, 8'hC3};
        vecs[3] = '{8'h3C, BIT_NS, 1'b0, 0, 1, 8'hC3};

        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data",  rx_data_o,      8'h00);
        check("reset_valid", rx_valid_o,     1'b0);
        check("reset_err",   rx_frame_err_o, 1'b0);
        check("reset_busy",  rx_busy_o,      1'b0);
        rst = 1'b0;
        idle_bits(1);

        // Table: nominal, +/-2% baud, stop-bit-low framing error.
        for (int k = 0; k < 4; k++) begin
            v0 = vcnt;
            e0 = ecnt;
            send_frame(vecs[k].data, vecs[k].bit_ns, vecs[k].stop);
            idle_bits(2);
            @(negedge clk);
            check($sformatf("vec%0d_valid_cnt", k), vcnt - v0, vecs[k].exp_v);
            check($sformatf("vec%0d_err_cnt", k),   ecnt - e0, vecs[k].exp_e);
            check($sformatf("vec%0d_data", k),      rx_data_o, vecs[k].exp_data);
            check($sformatf("vec%0d_busy", k),      rx_busy_o, 1'b0);
        end

        // Back-to-back frames with no idle gap.
        v0 = vcnt;
        send_frame(8'hA5, BIT_NS, 1'b1);
        send_frame(8'h00, BIT_NS, 1'b1);
        idle_bits(2);
        @(negedge clk);
        check("b2b_valid_cnt", vcnt - v0, 2);
        if (data_log.size() >= 2) begin
            check("b2b_first",  data_log[data_log.size()-2], 8'hA5);
            check("b2b_second", data_log[data_log.size()-1], 8'h00);
        end else begin
            check("b2b_log_size", data_log.size(), 2);
        end

        // Short low glitch is rejected at the half-bit check.
        v0 = vcnt;
        e0 = ecnt;
        rx_i = 1'b0;
        #1000;
        check("glitch_busy_mid", rx_busy_o, 1'b1);
        #1000;
        rx_i = 1'b1;
        repeat (HALF_BIT + 3) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_end", rx_busy_o, 1'b0);
        check("glitch_valid",    vcnt - v0, 0);
        check("glitch_err",      ecnt - e0, 0);

        // Framing error followed by a held-low line, then a good frame.
        v0 = vcnt;
        e0 = ecnt;
        prior = rx_data_o;
        send_frame(8'h3C, BIT_NS, 1'b0);
        #(5 * BIT_NS);
        check("brk_busy_held", rx_busy_o, 1'b1);
        check("brk_err_cnt",   ecnt - e0, 1);
        check("brk_valid_cnt", vcnt - v0, 0);
        check("brk_data_kept", rx_data_o, prior);
        idle_bits(1);
        check("brk_busy_rel",  rx_busy_o, 1'b0);
        send_frame(8'h81, BIT_NS, 1'b1);
        idle_bits(2);
        check("brk_next_valid", vcnt - v0, 1);
        check("brk_next_data",  rx_data_o, 8'h81);

        // Reset mid-frame after data bit 3 of 0x0F.
        v0 = vcnt;
        e0 = ecnt;
        rx_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1;
            #(BIT_NS);
        end
        @(negedge clk);
        rst  = 1'b1;
        rx_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", rx_data_o, 8'h00);
        check("abort_busy", rx_busy_o, 1'b0);
        idle_bits(12);
        check("abort_valid", vcnt - v0, 0);
        check("abort_err",   ecnt - e0, 0);
        send_frame(8'hFF, BIT_NS, 1'b1);
        idle_bits(2);
        check("abort_next_valid", vcnt - v0, 1);
        check("abort_next_data",  rx_data_o, 8'hFF);

        check("pulse_rules", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
